// File: rtl/chunk_row_issue_pkg.sv
// Shared configuration constants and state encoding for the chunk row issuer.
// Optional statistics counters are enabled with the CHUNK_ROW_ISSUE_STAT_EN macro.
package chunk_row_issue_pkg;

  localparam int WORK_BW        = 16;
  localparam int DIM            = 3;
  localparam int N_ICFG         = 2;
  localparam int GLOBAL_ADDR_BW = 16;
  localparam int ROW_CNT_BW     = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_e;

endpackage

// File: rtl/chunk_row_issue_linear_dot.sv
// Combinational base + sum(offset[d] * stride[d]), every product and sum wrapping
// modulo 2^BW_OUT.
module chunk_row_issue_linear_dot #(
  parameter int BW_IN  = 16,
  parameter int BW_OUT = 16,
  parameter int DIM    = 3
) (
  input  logic [BW_OUT-1:0]           base_i,
  input  logic [DIM-1:0][BW_IN-1:0]   ofs_i,
  input  logic [DIM-1:0][BW_OUT-1:0]  stride_i,
  output logic [BW_OUT-1:0]           sum_o
);

  // The multiply runs at the wider operand width; its low BW_OUT bits are the
  // product modulo 2^BW_OUT.
  localparam int PW = (BW_IN > BW_OUT) ? BW_IN : BW_OUT;

  always_comb begin
    sum_o = base_i;
    for (int d = 0; d < DIM; d++) begin
      sum_o = sum_o + BW_OUT'(PW'(ofs_i[d]) * PW'(stride_i[d]));
    end
  end

endmodule

// File: rtl/chunk_row_issue.sv
// Turns each accepted multi-dim chunk offset into a sequence of row requests.
// Defining CHUNK_ROW_ISSUE_STAT_EN adds skipped-chunk and request counters.
module chunk_row_issue
  import chunk_row_issue_pkg::*;
#(
  parameter  int WBW     = WORK_BW,
  parameter  int DIM     = chunk_row_issue_pkg::DIM,
  parameter  int N_ICFG  = chunk_row_issue_pkg::N_ICFG,
  parameter  int GBW     = GLOBAL_ADDR_BW,
  parameter  int CBW     = ROW_CNT_BW,
  localparam int ICFG_BW = $clog2(N_ICFG + 1)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_mofs_rdy,
  output logic                                 i_mofs_ack,
  input  logic [DIM-1:0][WBW-1:0]              i_mofs,
  input  logic [ICFG_BW-1:0]                   i_id,
  input  logic                                 i_skip,
  input  logic [N_ICFG-1:0][DIM-1:0][GBW-1:0]  i_global_lstrides,
  input  logic [N_ICFG-1:0][GBW-1:0]           i_global_bases,
  input  logic [N_ICFG-1:0][GBW-1:0]           i_row_pitch,
  input  logic [N_ICFG-1:0][CBW-1:0]           i_nrow,
  input  logic [N_ICFG-1:0][CBW-1:0]           i_row_len,
  output logic                                 o_addr_rdy,
  input  logic                                 o_addr_ack,
  output logic [GBW-1:0]                       o_addr,
  output logic [CBW-1:0]                       o_len,
  output logic [ICFG_BW-1:0]                   o_id,
  output logic                                 o_last
`ifdef CHUNK_ROW_ISSUE_STAT_EN
  ,
  output logic [31:0]                          o_nskip,
  output logic [31:0]                          o_nreq
`endif
);

  // Config tables padded to every encodable id; unused ids read as nrow=0 and
  // therefore behave as skipped chunks.
  localparam int NCFG_PAD = 1 << ICFG_BW;

  logic [NCFG_PAD-1:0][DIM-1:0][GBW-1:0] lstr_pad;
  logic [NCFG_PAD-1:0][GBW-1:0]          base_pad;
  logic [NCFG_PAD-1:0][GBW-1:0]          pitch_pad;
  logic [NCFG_PAD-1:0][CBW-1:0]          nrow_pad;
  logic [NCFG_PAD-1:0][CBW-1:0]          len_pad;

  always_comb begin
    lstr_pad  = '0;
    base_pad  = '0;
    pitch_pad = '0;
    nrow_pad  = '0;
    len_pad   = '0;
    for (int c = 0; c < N_ICFG; c++) begin
      lstr_pad[c]  = i_global_lstrides[c];
      base_pad[c]  = i_global_bases[c];
      pitch_pad[c] = i_row_pitch[c];
      nrow_pad[c]  = i_nrow[c];
      len_pad[c]   = i_row_len[c];
    end
  end

  logic [GBW-1:0] start_addr;

  chunk_row_issue_linear_dot #(
    .BW_IN  (WBW),
    .BW_OUT (GBW),
    .DIM    (DIM)
  ) u_dot (
    .base_i   (base_pad[i_id]),
    .ofs_i    (i_mofs),
    .stride_i (lstr_pad[i_id]),
    .sum_o    (start_addr)
  );

  issue_state_e         state_q, state_d;
  logic [GBW-1:0]       addr_q,  addr_d;
  logic [CBW-1:0]       len_q,   len_d;
  logic [ICFG_BW-1:0]   id_q,    id_d;
  logic [CBW-1:0]       row_q,   row_d;
  logic                 accept;
  logic                 skip_chunk;
  logic                 row_last;

  assign o_addr_rdy = (state_q == ST_ISSUE);
  assign row_last   = (row_q == nrow_pad[id_q] - CBW'(1));
  assign o_last     = o_addr_rdy && row_last;
  assign skip_chunk = i_skip || (nrow_pad[i_id] == '0);

  // A new chunk is taken while idle or in the very cycle the last row is acked,
  // so consecutive chunks issue without a bubble.
  assign accept     = i_rst && i_mofs_rdy &&
                      ((state_q == ST_IDLE) || (o_addr_ack && o_last));
  assign i_mofs_ack = accept;

  assign o_addr = addr_q;
  assign o_len  = len_q;
  assign o_id   = id_q;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    row_d   = row_q;
    if (accept) begin
      if (skip_chunk) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_ISSUE;
        addr_d  = start_addr;
        len_d   = len_pad[i_id];
        id_d    = i_id;
        row_d   = '0;
      end
    end else if (o_addr_rdy && o_addr_ack) begin
      if (o_last) begin
        state_d = ST_IDLE;
      end else begin
        addr_d = addr_q + pitch_pad[id_q];
        row_d  = row_q + CBW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      row_q   <= row_d;
    end
  end

`ifdef CHUNK_ROW_ISSUE_STAT_EN
  logic [31:0] nskip_q;
  logic [31:0] nreq_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      nskip_q <= '0;
      nreq_q  <= '0;
    end else begin
      if (accept && skip_chunk)     nskip_q <= nskip_q + 32'd1;
      if (o_addr_rdy && o_addr_ack) nreq_q  <= nreq_q + 32'd1;
    end
  end

  assign o_nskip = nskip_q;
  assign o_nreq  = nreq_q;
`endif

endmodule

// File: tb/tb_chunk_row_issue.sv
// Directed bench for chunk_row_issue with a queue-based request model checked every cycle.
`timescale 1ns/1ps
module tb_chunk_row_issue;

  localparam int WBW     = 16;
  localparam int DIM     = 3;
  localparam int N_ICFG  = 2;
  localparam int GBW     = 16;
  localparam int CBW     = 8;
  localparam int ICFG_BW = 2;

  logic clk;
  logic rst;
  logic mofs_rdy;
  logic mofs_ack;
  logic [DIM-1:0][WBW-1:0]             mofs;
  logic [ICFG_BW-1:0]                  id;
  logic                                skip;
  logic [N_ICFG-1:0][DIM-1:0][GBW-1:0] lstr;
  logic [N_ICFG-1:0][GBW-1:0]          base;
  logic [N_ICFG-1:0][GBW-1:0]          pitch;
  logic [N_ICFG-1:0][CBW-1:0]          nrow;
  logic [N_ICFG-1:0][CBW-1:0]          row_len;
  logic                                addr_rdy;
  logic                                addr_ack;
  logic                                ack_en;
  logic [GBW-1:0]                      addr;
  logic [CBW-1:0]                      len;
  logic [ICFG_BW-1:0]                  oid;
  logic                                last;
`ifdef CHUNK_ROW_ISSUE_STAT_EN
  logic [31:0] nskip;
  logic [31:0] nreq;
  logic [31:0] nskip_m;
  logic [31:0] nreq_m;
`endif

  int n_checks = 0;
  int n_errors = 0;

  chunk_row_issue #(
    .WBW    (WBW),
    .DIM    (DIM),
    .N_ICFG (N_ICFG),
    .GBW    (GBW),
    .CBW    (CBW)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_mofs_rdy        (mofs_rdy),
    .i_mofs_ack        (mofs_ack),
    .i_mofs            (mofs),
    .i_id              (id),
    .i_skip            (skip),
    .i_global_lstrides (lstr),
    .i_global_bases    (base),
    .i_row_pitch       (pitch),
    .i_nrow            (nrow),
    .i_row_len         (row_len),
    .o_addr_rdy        (addr_rdy),
    .o_addr_ack        (addr_ack),
    .o_addr            (addr),
    .o_len             (len),
    .o_id              (oid),
    .o_last            (last)
`ifdef CHUNK_ROW_ISSUE_STAT_EN
    ,
    .o_nskip           (nskip),
    .o_nreq            (nreq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The consumer only ever acks a request that is being offered.
  assign addr_ack = ack_en && addr_rdy;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [GBW-1:0]     addr;
    logic [CBW-1:0]     len;
    logic [ICFG_BW-1:0] id;
    logic               last;
  } req_t;

  req_t exp_q[$];

  function automatic logic [GBW-1:0] model_start(input logic c, input logic [DIM-1:0][WBW-1:0] m);
    logic [GBW-1:0] a;
    a = base[c];
    for (int d = 0; d < DIM; d++) a = a + GBW'(m[d] * lstr[c][d]);
    return a;
  endfunction

  task automatic model_accept();
    logic           c;
    logic [GBW-1:0] a;
    req_t           r;
    int             n;
    c = id[0];
    n = int'(nrow[c]);
    if (skip || (id > 2'd1) || (n == 0)) begin
`ifdef CHUNK_ROW_ISSUE_STAT_EN
      nskip_m = nskip_m + 32'd1;
`endif
      return;
    end
    a = model_start(c, mofs);
    for (int k = 0; k < n; k++) begin
      r.addr = a;
      r.len  = row_len[c];
      r.id   = id;
      r.last = (k == n - 1);
      exp_q.push_back(r);
      a = a + pitch[c];
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin
    logic exp_ack;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
`ifdef CHUNK_ROW_ISSUE_STAT_EN
        nskip_m = '0;
        nreq_m  = '0;
        check("rst_nskip", nskip, 32'd0);
        check("rst_nreq", nreq, 32'd0);
`endif
        check("rst_rdy", 32'(addr_rdy), 32'd0);
        check("rst_mofs_ack", 32'(mofs_ack), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_len", 32'(len), 32'd0);
        check("rst_id", 32'(oid), 32'd0);
        check("rst_last", 32'(last), 32'd0);
      end else begin
        exp_ack = mofs_rdy && ((exp_q.size() == 0) || (addr_ack && exp_q.size() == 1));
        check("cyc_rdy", 32'(addr_rdy), 32'(exp_q.size() != 0));
        check("cyc_mofs_ack", 32'(mofs_ack), 32'(exp_ack));
        if (exp_q.size() != 0) begin
          check("cyc_addr", 32'(addr), 32'(exp_q[0].addr));
          check("cyc_len", 32'(len), 32'(exp_q[0].len));
          check("cyc_id", 32'(oid), 32'(exp_q[0].id));
          check("cyc_last", 32'(last), 32'(exp_q[0].last));
        end
`ifdef CHUNK_ROW_ISSUE_STAT_EN
        check("cyc_nskip", nskip, nskip_m);
        check("cyc_nreq", nreq, nreq_m);
`endif
        if (addr_ack && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
`ifdef CHUNK_ROW_ISSUE_STAT_EN
          nreq_m = nreq_m + 32'd1;
`endif
        end
        if (exp_ack) model_accept();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic present(input logic [DIM-1:0][WBW-1:0] m, input logic [ICFG_BW-1:0] c, input logic s);
    mofs     = m;
    id       = c;
    skip     = s;
    mofs_rdy = 1'b1;
  endtask

  task automatic wait_accept();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mofs_ack) break;
    end
    check("accept_seen", 32'(mofs_ack), 32'd1);
    @(posedge clk);
    #1;
    mofs_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!addr_rdy) break;
    end
    check("drain", 32'(addr_rdy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    mofs_rdy = 1'b0;
    mofs     = '0;
    id       = '0;
    skip     = 1'b0;
    ack_en   = 1'b0;
    lstr[0]    = {16'd4096, 16'd64, 16'd1};
    base[0]    = 16'h1000;
    pitch[0]   = 16'd64;
    nrow[0]    = 8'd2;
    row_len[0] = 8'd8;
    lstr[1]    = {16'h0100, 16'h0010, 16'h0001};
    base[1]    = 16'hFFF0;
    pitch[1]   = 16'h0040;
    nrow[1]    = 8'd1;
    row_len[1] = 8'd4;

    check("model_start_basic", 32'(model_start(1'b0, {16'd1, 16'd3, 16'd2})), 32'h20C2);
    check("model_start_wrap", 32'(model_start(1'b1, {16'd0, 16'd1, 16'h10})), 32'h0010);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Basic two-row chunk.
    ack_en = 1'b1;
    present({16'd1, 16'd3, 16'd2}, 2'd0, 1'b0);
    wait_accept();
    @(negedge clk);
    check("basic_row0_addr", 32'(addr), 32'h20C2);
    check("basic_row0_last", 32'(last), 32'd0);
    check("basic_row0_len", 32'(len), 32'd8);
    @(negedge clk);
    check("basic_row1_addr", 32'(addr), 32'h2102);
    check("basic_row1_last", 32'(last), 32'd1);
    check("basic_row1_len", 32'(len), 32'd8);
    wait_idle();
`ifdef CHUNK_ROW_ISSUE_STAT_EN
    check("stat_nreq_basic", nreq, 32'd2);
`endif

    // Skipped chunk, then a chunk whose config has zero rows.
    present({16'd1, 16'd3, 16'd2}, 2'd0, 1'b1);
    wait_accept();
    repeat (3) begin
      @(negedge clk);
      check("skip_no_rdy", 32'(addr_rdy), 32'd0);
    end
    nrow[1] = 8'd0;
    present({16'd0, 16'd0, 16'd7}, 2'd1, 1'b0);
    wait_accept();
    repeat (2) begin
      @(negedge clk);
      check("nrow0_no_rdy", 32'(addr_rdy), 32'd0);
    end
`ifdef CHUNK_ROW_ISSUE_STAT_EN
    check("stat_nskip", nskip, 32'd2);
`endif
    nrow[1] = 8'd1;
    @(posedge clk);
    #1;

    // Stall: no ack for five cycles while the next chunk waits.
    ack_en = 1'b0;
    present({16'd1, 16'd3, 16'd2}, 2'd0, 1'b0);
    wait_accept();
    present({16'd5, 16'd0, 16'd0}, 2'd0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("stall_rdy", 32'(addr_rdy), 32'd1);
      check("stall_addr", 32'(addr), 32'h20C2);
      check("stall_len", 32'(len), 32'd8);
      check("stall_id", 32'(oid), 32'd0);
      check("stall_last", 32'(last), 32'd0);
      check("stall_mofs_ack", 32'(mofs_ack), 32'd0);
    end
    @(posedge clk);
    #1 ack_en = 1'b1;
    wait_accept();
    @(negedge clk);
    check("stall_next_addr", 32'(addr), 32'h6000);
    wait_idle();

    // Back-to-back single-row chunks with address wrap.
    present({16'd0, 16'd1, 16'h10}, 2'd1, 1'b0);
    wait_accept();
    present({16'd1, 16'd0, 16'd0}, 2'd1, 1'b0);
    @(negedge clk);
    check("b2b_first_rdy", 32'(addr_rdy), 32'd1);
    check("b2b_first_addr", 32'(addr), 32'h0010);
    check("b2b_first_last", 32'(last), 32'd1);
    check("b2b_first_len", 32'(len), 32'd4);
    check("b2b_first_id", 32'(oid), 32'd1);
    check("b2b_same_cycle_ack", 32'(mofs_ack), 32'd1);
    @(posedge clk);
    #1 mofs_rdy = 1'b0;
    @(negedge clk);
    check("b2b_second_rdy", 32'(addr_rdy), 32'd1);
    check("b2b_second_addr", 32'(addr), 32'h00F0);
    wait_idle();

    // Reset in the middle of a four-row chunk.
    nrow[0] = 8'd4;
    present({16'd1, 16'd3, 16'd2}, 2'd0, 1'b0);
    wait_accept();
    @(negedge clk);
    check("rstmid_row0", 32'(addr), 32'h20C2);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rstmid_rdy_async", 32'(addr_rdy), 32'd0);
    @(negedge clk);
    check("rstmid_addr", 32'(addr), 32'd0);
    check("rstmid_len", 32'(len), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("rstmid_no_rows", 32'(addr_rdy), 32'd0);
    end
    nrow[0] = 8'd2;

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
